poly_add_ctrl: RTL
==================

# poly_add_ctrl

Sequencer that streams two coefficient memories (A, B) through one `mod_add` datapath instance and writes the sums to a result memory (C). It computes C[i] = (A[i] + B[i]) mod Q for i = 0..len-1. It sits between the NTT top-level control, which pulses `start` and waits for `done`, and the coefficient RAMs. It is the pointwise-addition step of the polynomial pipeline.

## Interface
- WIDTH, 32, coefficient bit width; passed to `mod_add`
- Q, 3329, modulus; passed to `mod_add`
- N, 256, maximum polynomial length
- ADDR_W, $clog2(N), address width
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- len  input  ADDR_W+1  coefficient count, latched on accepted start; 0 means N; values > N saturate to N
- busy  output  1  high from the cycle after accepted start through the last write cycle
- done  output  1  one-cycle pulse in the cycle after the last write
- rd_en  output  1  read strobe, shared by memories A and B
- rd_addr  output  ADDR_W  read index
- a_rdata  input  WIDTH  A[rd_addr], valid the cycle after rd_en (1-cycle RAM)
- b_rdata  input  WIDTH  B[rd_addr], valid the cycle after rd_en
- wr_en  output  1  write strobe to memory C
- wr_addr  output  ADDR_W  write index
- wr_data  output  WIDTH  (A[i]+B[i]) mod Q

## Operation
- FSM states:
  - IDLE: waiting for `start`.
  - RUN: issuing reads.
  - DRAIN: retiring in-flight results.
  - DONE: single cycle; pulses `done`.
- IDLE→RUN on `start`=1. `len` is latched into `len_q` (0 or >N becomes N), and read counter `rd_cnt` and write counter `wr_cnt` are cleared.
- RUN: `rd_en`=1 with `rd_addr`=`rd_cnt` every cycle; `rd_cnt` increments. Transition to DRAIN in the cycle where `rd_cnt`=`len_q`-1 issues.
- Pipeline, three stages, no stall:
  - P0: read issue. Captures index into `idx_p1` and sets `v_p1`.
  - P1: `a_rdata`/`b_rdata` valid and feed `mod_add` combinationally. At the clock edge the sum is registered into `wr_data`, `idx_p1` into `wr_addr`, and `v_p1` into `wr_en`.
  - P2: registered write presented.
- DRAIN: no reads. Stay until the write with `wr_cnt`=`len_q`-1 is presented, then go to DONE.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- `start` in any state other than IDLE is ignored; it is not queued.
- Operands are assumed < Q. Out-of-range operands produce the `mod_add` result unchanged; the controller does not check them.
- Index counters are ADDR_W+1 bits wide, so `len_q`=N terminates without wrap. `rd_addr` and `wr_addr` are the low ADDR_W bits.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0; FSM in IDLE; all valid bits 0.
- `rst` asserted mid-operation: the next edge forces reset values. No further `wr_en` pulses occur, and no `done` is issued for the aborted job.
- Cycle 0 = cycle `start` is sampled high in IDLE.
  - `rd_en` high cycles 1..L.
  - `wr_en` high cycles 3..L+2, with `wr_addr`=k in cycle k+3.
  - `busy` high cycles 1..L+2.
  - `done` high in cycle L+3.
  - IDLE in cycle L+4, so the earliest next accepted `start` is cycle L+4.
- Throughput: one coefficient per cycle. Read-to-write latency is 2 cycles.
- L=1: `rd_en` in cycle 1, `wr_en` in cycle 3, `done` in cycle 4. FSM goes RUN (1 cycle) → DRAIN (2 cycles) → DONE.
- `start` and `done` in the same cycle: `start` is ignored, because the FSM is in DONE, not IDLE.

## Structure
- Shared package `ntt_pkg` holds:
  - default WIDTH, Q and N constants;
  - the `poly_add_state_e` enum (IDLE, RUN, DRAIN, DONE).
- Exactly one sub-module: a single `mod_add` instance (WIDTH, Q passed through), fed by `a_rdata`/`b_rdata`, with its output registered into `wr_data`.
- No other arithmetic in the block besides counters and compares.

## Test plan
- Q=3329, L=4; A={3328,1000,3000,0}, B={1,2000,3000,0} → C={0,3000,2671,0}. `wr_en` cycles 3..6, `done` in cycle 7.
- `len`=0 with N=256, A[i]=i, B[i]=3328 → C[0]=3328 and C[i]=i-1 for i≥1. Exactly 256 writes, `done` in cycle 259, `rd_addr` never exceeds 255.
- L=1, A[0]=5, B[0]=7 → a single write C[0]=12 in cycle 3. `busy` high cycles 1-3, `done` in cycle 4.
- `start` re-pulsed in cycles 2 and L+3 of a running job → ignored: no extra reads or writes, exactly one `done`. `start` in cycle L+4 → new job begins.
- `rst` raised in cycle 3 of an L=8 job → from cycle 4 all outputs 0. Only the one write already presented in cycle 3 occurs, and no `done` is issued.
- Back-to-back jobs L=3 then L=2 with different data → C contents correct for each job, and the `done` pulses are separated by exactly 6 cycles.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and types for the polynomial arithmetic blocks.
// Default coefficient width, modulus and maximum length live here.
package ntt_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int Q_DEF     = 3329;
  localparam int N_DEF     = 256;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } poly_add_state_e;

endpackage

// File: rtl/mod_add.sv
// Combinational modular adder: sum = (a + b) mod Q for operands below Q.
// A single conditional subtraction; larger operands are not corrected.
module mod_add
  import ntt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int Q     = Q_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);

  function automatic logic [WIDTH-1:0] reduce(input logic [WIDTH:0] s);
    logic [WIDTH:0] d;
    d = s - QX;
    if (s >= QX) return d[WIDTH-1:0];
    return s[WIDTH-1:0];
  endfunction

  assign sum = reduce({1'b0, a} + {1'b0, b});

endmodule

// File: rtl/poly_add_ctrl.sv
// Streams A and B through one mod_add and writes C[i] = (A[i]+B[i]) mod Q.
// Reads issue one per cycle; results land two cycles later, no stalls.
module poly_add_ctrl
  import ntt_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int Q      = Q_DEF,
  parameter int N      = N_DEF,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  a_rdata,
  input  logic [WIDTH-1:0]  b_rdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  poly_add_state_e state, state_nxt;

  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [ADDR_W-1:0] idx_p1;
  logic              v_p1;
  logic [WIDTH-1:0]  sum_p1;
  logic              last_rd;
  logic              last_wr;

  // Zero and oversized lengths both mean a full-length polynomial.
  function automatic logic [CNT_W-1:0] sat_len(input logic [CNT_W-1:0] l);
    if (l == '0 || l > N_CNT) return N_CNT;
    return l;
  endfunction

  assign last_rd = (rd_cnt == len_q - ONE);
  assign last_wr = wr_en && (wr_cnt == len_q - ONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_rd) state_nxt = DRAIN;
      DRAIN:   if (last_wr) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_en   = (state == RUN);
  assign rd_addr = rd_cnt[ADDR_W-1:0];
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      len_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      v_p1   <= 1'b0;
      wr_en  <= 1'b0;
    end else begin
      state <= state_nxt;
      v_p1  <= rd_en;
      wr_en <= v_p1;
      if (state == IDLE && start) begin
        len_q  <= sat_len(len);
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (rd_en) rd_cnt <= rd_cnt + ONE;
        if (wr_en) wr_cnt <= wr_cnt + ONE;
      end
    end
  end

  // P0 -> P1: read index follows the RAM access.
  always_ff @(posedge clk) begin
    idx_p1 <= rd_addr;
  end

  // P1: RAM data valid, sum formed combinationally.
  mod_add #(
    .WIDTH(WIDTH),
    .Q    (Q)
  ) u_mod_add (
    .a  (a_rdata),
    .b  (b_rdata),
    .sum(sum_p1)
  );

  // P1 -> P2: registered write presented to memory C.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      wr_data <= '0;
    end else if (v_p1) begin
      wr_addr <= idx_p1;
      wr_data <= sum_p1;
    end
  end

endmodule
